// File: rtl/sa_tile_sequencer.sv
// rtl/sa_tile_sequencer.sv - weight-stationary tile-pass sequencer for the FP6 systolic array
// Optional SA_SEQ_META_EN adds the N:M sparsity metadata read/valid ports.
module sa_tile_sequencer #(
    parameter int NUM_REGS     = 8,
    parameter int NUM_REG_ROWS = 16,
    parameter int X            = 3,
    parameter int Y            = 3,
    parameter int SA_LAT       = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [$clog2(NUM_REGS)-1:0]     cmd_act_reg,
    input  logic [$clog2(NUM_REGS)-1:0]     cmd_wgt_reg,
    input  logic [$clog2(NUM_REGS)-1:0]     cmd_dst_reg,
    input  logic [$clog2(NUM_REG_ROWS):0]   cmd_k,
    output logic                            rf_rd_en,
    output logic [$clog2(NUM_REGS)-1:0]     rf_rd_reg,
    output logic [$clog2(NUM_REG_ROWS)-1:0] rf_rd_row,
    output logic                            sa_wload,
    output logic                            sa_acc_clr,
    output logic [X-1:0]                    sa_act_vld,
    output logic                            rf_wr_en,
    output logic [$clog2(NUM_REGS)-1:0]     rf_wr_reg,
    output logic [$clog2(NUM_REG_ROWS)-1:0] rf_wr_row,
`ifdef SA_SEQ_META_EN
    output logic                            meta_rd_en,
    output logic [$clog2(NUM_REG_ROWS)-1:0] meta_rd_row,
    output logic [X-1:0]                    sa_meta_vld,
`endif
    output logic                            busy,
    output logic                            done,
    output logic                            err
);
    localparam int GW = $clog2(NUM_REGS);
    localparam int RW = $clog2(NUM_REG_ROWS);
    localparam int KW = RW + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [GW-1:0]   r_act, r_wgt, r_dst;
    logic [KW-1:0]   r_k;
    logic            r_err;
    logic [RW-1:0]   r_cnt;
    logic            r_wload;
    logic [X-1:0]    r_skew;
    logic [RW-1:0]   r_act_row;
    logic            r_wr_v   [SA_LAT];
    logic [RW-1:0]   r_wr_row [SA_LAT];

    logic w_accept, w_illegal, w_load_last, w_stream_last, w_last_wr, w_act_rd;

    assign w_accept      = cmd_valid && (r_state == S_IDLE);
    assign w_illegal     = (cmd_k == '0) || (cmd_k > KW'(NUM_REG_ROWS));
    assign w_load_last   = (r_cnt == RW'(Y - 1));
    assign w_stream_last = ({1'b0, r_cnt} == r_k - KW'(1));
    // Completion is keyed on the last row leaving the write-back delay line.
    assign w_last_wr     = r_wr_v[SA_LAT-1] && ({1'b0, r_wr_row[SA_LAT-1]} == r_k - KW'(1));
    assign w_act_rd      = (r_state == S_STREAM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = w_illegal ? S_DONE : S_LOAD_W;
            S_LOAD_W: if (w_load_last) w_next = S_STREAM;
            S_STREAM: if (w_stream_last) w_next = S_DRAIN;
            S_DRAIN:  if (w_last_wr) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (r_state == S_IDLE);
        busy       = (r_state != S_IDLE);
        rf_rd_en   = (r_state == S_LOAD_W) || (r_state == S_STREAM);
        rf_rd_reg  = (r_state == S_STREAM) ? r_act : r_wgt;
        rf_rd_row  = r_cnt;
        sa_acc_clr = (r_state == S_STREAM) && (r_cnt == '0);
        done       = (r_state == S_DONE);
        err        = (r_state == S_DONE) && r_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act <= '0;
            r_wgt <= '0;
            r_dst <= '0;
            r_k   <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_act <= cmd_act_reg;
                r_wgt <= cmd_wgt_reg;
                r_dst <= cmd_dst_reg;
                r_k   <= cmd_k;
                r_err <= w_illegal;
            end
            if (r_state == S_LOAD_W) begin
                r_cnt <= w_load_last ? '0 : r_cnt + RW'(1);
            end else if (r_state == S_STREAM) begin
                r_cnt <= r_cnt + RW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Read data lands one cycle after the strobe, so weight latch and row valids trail by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wload   <= 1'b0;
            r_skew    <= '0;
            r_act_row <= '0;
            for (int i = 0; i < SA_LAT; i++) begin
                r_wr_v[i]   <= 1'b0;
                r_wr_row[i] <= '0;
            end
        end else begin
            r_wload   <= (r_state == S_LOAD_W);
            r_skew[0] <= w_act_rd;
            for (int i = 1; i < X; i++) begin
                r_skew[i] <= r_skew[i-1];
            end
            r_act_row   <= r_cnt;
            r_wr_v[0]   <= r_skew[0];
            r_wr_row[0] <= r_act_row;
            for (int i = 1; i < SA_LAT; i++) begin
                r_wr_v[i]   <= r_wr_v[i-1];
                r_wr_row[i] <= r_wr_row[i-1];
            end
        end
    end

    assign sa_wload   = r_wload;
    assign sa_act_vld = r_skew;
    assign rf_wr_en   = r_wr_v[SA_LAT-1];
    assign rf_wr_row  = r_wr_row[SA_LAT-1];
    assign rf_wr_reg  = r_dst;

`ifdef SA_SEQ_META_EN
    assign meta_rd_en  = w_act_rd;
    assign meta_rd_row = r_cnt;
    assign sa_meta_vld = r_skew;
`endif
endmodule

// File: tb/tb_sa_tile_sequencer.sv
// tb/tb_sa_tile_sequencer.sv - directed self-checking bench for sa_tile_sequencer
// Build with SA_SEQ_META_EN to also check the metadata ports.
module tb_sa_tile_sequencer;
    localparam int NR  = 8;
    localparam int NRR = 16;
    localparam int X   = 3;
    localparam int Y   = 3;
    localparam int LAT = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_act_reg, cmd_wgt_reg, cmd_dst_reg;
    logic [4:0] cmd_k;
    logic       rf_rd_en;
    logic [2:0] rf_rd_reg;
    logic [3:0] rf_rd_row;
    logic       sa_wload, sa_acc_clr;
    logic [X-1:0] sa_act_vld;
    logic       rf_wr_en;
    logic [2:0] rf_wr_reg;
    logic [3:0] rf_wr_row;
    logic       busy, done, err;
`ifdef SA_SEQ_META_EN
    logic       meta_rd_en;
    logic [3:0] meta_rd_row;
    logic [X-1:0] sa_meta_vld;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    sa_tile_sequencer #(.NUM_REGS(NR), .NUM_REG_ROWS(NRR), .X(X), .Y(Y), .SA_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_act_reg(cmd_act_reg), .cmd_wgt_reg(cmd_wgt_reg), .cmd_dst_reg(cmd_dst_reg), .cmd_k(cmd_k),
        .rf_rd_en(rf_rd_en), .rf_rd_reg(rf_rd_reg), .rf_rd_row(rf_rd_row),
        .sa_wload(sa_wload), .sa_acc_clr(sa_acc_clr), .sa_act_vld(sa_act_vld),
        .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_row(rf_wr_row),
`ifdef SA_SEQ_META_EN
        .meta_rd_en(meta_rd_en), .meta_rd_row(meta_rd_row), .sa_meta_vld(sa_meta_vld),
`endif
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rd_en"}, rf_rd_en, 0);
        chk({tag, "_wr_en"}, rf_wr_en, 0);
        chk({tag, "_wload"}, sa_wload, 0);
        chk({tag, "_acc_clr"}, sa_acc_clr, 0);
        chk({tag, "_act_vld"}, sa_act_vld, 0);
    endtask

    // Accept a command at edge 0, then check cycles 1..ncyc (sampled 1 time unit after each edge).
    task automatic run_cmd(input int act, input int wgt, input int dst, input int k,
                           input bit hold, input int ncyc);
        int dc;
        int row;
        int rdc[16];
        bit erd, ew;
        logic [X-1:0] ev;
        foreach (rdc[i]) rdc[i] = 100000;
        cmd_act_reg = 3'(act);
        cmd_wgt_reg = 3'(wgt);
        cmd_dst_reg = 3'(dst);
        cmd_k       = 5'(k);
        cmd_valid   = 1'b1;
        chk("accept_ready", cmd_ready, 1);
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
        dc = Y + k + 2 + LAT;
        for (int c = 1; c <= ncyc; c++) begin
            erd = (c >= 1) && (c <= Y + k);
            chk("rd_en", rf_rd_en, erd);
            if (erd) begin
                chk("rd_reg", rf_rd_reg, (c <= Y) ? wgt : act);
                chk("rd_row", rf_rd_row, (c <= Y) ? c - 1 : c - Y - 1);
                if (c > Y) rdc[c-Y-1] = c;
            end
            chk("wload", sa_wload, (c >= 2) && (c <= Y + 1));
            chk("acc_clr", sa_acc_clr, c == Y + 1);
            for (int i = 0; i < X; i++) ev[i] = (c >= Y + 2 + i) && (c <= Y + k + 1 + i);
            chk("act_vld", sa_act_vld, ev);
            ew = (c >= Y + 2 + LAT) && (c <= Y + k + 1 + LAT);
            chk("wr_en", rf_wr_en, ew);
            if (ew) begin
                row = c - (Y + 2 + LAT);
                chk("wr_row", rf_wr_row, row);
                chk("wr_reg", rf_wr_reg, dst);
                chk("wr_after_rd", rdc[row] < c, 1);
            end
            chk("done", done, c == dc);
            chk("err", err, 0);
            chk("busy", busy, c <= dc);
            chk("cmd_ready", cmd_ready, c > dc);
`ifdef SA_SEQ_META_EN
            chk("meta_rd_en", meta_rd_en, erd && (c > Y));
            if (erd && c > Y) chk("meta_rd_row", meta_rd_row, c - Y - 1);
            chk("sa_meta_vld", sa_meta_vld, ev);
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic err_cmd(input int k);
        cmd_act_reg = 3'd1;
        cmd_wgt_reg = 3'd2;
        cmd_dst_reg = 3'd3;
        cmd_k       = 5'(k);
        cmd_valid   = 1'b1;
        chk("err_accept_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("err_c1_done", done, 1);
        chk("err_c1_err", err, 1);
        chk("err_c1_rd_en", rf_rd_en, 0);
        chk("err_c1_wr_en", rf_wr_en, 0);
        chk("err_c1_busy", busy, 1);
        chk("err_c1_ready", cmd_ready, 0);
        @(posedge clk); #1;
        chk_idle_outputs("err_c2");
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_act_reg = '0;
        cmd_wgt_reg = '0;
        cmd_dst_reg = '0;
        cmd_k       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmd(1, 2, 3, 4, 1'b0, 15);
        run_cmd(5, 2, 5, 16, 1'b0, 27);
        err_cmd(0);
        err_cmd(17);

        run_cmd(1, 2, 3, 4, 1'b1, 14);
        run_cmd(4, 6, 7, 4, 1'b0, 7);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk_idle_outputs("abort");
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            chk("post_abort_wr_en", rf_wr_en, 0);
            chk("post_abort_done", done, 0);
            chk("post_abort_busy", busy, 0);
            @(posedge clk); #1;
        end

        run_cmd(0, 1, 2, 1, 1'b0, Y + 1 + 2 + LAT + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
